// File: rtl/mul8_pipeline.sv
// Four-stage pipelined 8x8 unsigned multiplier returning the low 8 bits of the product.
// Data registers load only on their incoming valid bit; the valid bit shifts every cycle.
module mul8_pipeline (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o,
    output logic       valid_o
);

    logic [7:0] s1_a;
    logic [7:0] s1_b;
    logic       s1_v;
    logic [7:0] s2_sum [4];
    logic       s2_v;
    logic [7:0] s3_sum [2];
    logic       s3_v;
    logic [7:0] pp     [8];

    // Partial products are truncated to 8 bits, so bits shifted past bit 7 vanish here.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            pp[k] = 8'(s1_a << k) & {8{s1_b[k]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a    <= 8'h00;
            s1_b    <= 8'h00;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s3_v    <= 1'b0;
            p_o     <= 8'h00;
            valid_o <= 1'b0;
            for (int i = 0; i < 4; i++) s2_sum[i] <= 8'h00;
            for (int i = 0; i < 2; i++) s3_sum[i] <= 8'h00;
        end else begin
            s1_v    <= valid_i;
            s2_v    <= s1_v;
            s3_v    <= s2_v;
            valid_o <= s3_v;
            if (valid_i) begin
                s1_a <= a_i;
                s1_b <= b_i;
            end
            if (s1_v) begin
                for (int i = 0; i < 4; i++) s2_sum[i] <= pp[2*i] + pp[2*i+1];
            end
            if (s2_v) begin
                s3_sum[0] <= s2_sum[0] + s2_sum[1];
                s3_sum[1] <= s2_sum[2] + s2_sum[3];
            end
            if (s3_v) begin
                p_o <= s3_sum[0] + s3_sum[1];
            end
        end
    end

endmodule

// File: tb/tb_mul8_pipeline.sv
// Directed bench for mul8_pipeline: a 4-deep valid delay line plus an expected-result queue
// predict valid_o and p_o after every clock edge.
module tb_mul8_pipeline;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] a_i = 8'h00;
    logic [7:0] b_i = 8'h00;
    logic [7:0] p_o;
    logic       valid_o;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];
    logic [3:0] vpipe = 4'b0000;
    logic [7:0] exp_p = 8'h00;

    mul8_pipeline dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(valid_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .p_o    (p_o),
        .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    // Drive one cycle, advance the reference delay line, then compare 1 ns after the edge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input string tag);
        valid_i = v;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        #1;
        if (v) exp_q.push_back(exp);
        vpipe = {vpipe[2:0], v};
        if (vpipe[3]) begin
            if (exp_q.size() == 0) begin
                checks++;
                $error("FAIL %s: scoreboard empty when a result was due", tag);
            end else begin
                exp_p = exp_q.pop_front();
            end
        end
        check({tag, "_valid"}, {7'b0, valid_o}, {7'b0, vpipe[3]});
        check({tag, "_p"}, p_o, exp_p);
        @(negedge clk);
    endtask

    task automatic reset_step(input string tag);
        valid_i = 1'($urandom_range(0, 1));
        a_i     = 8'($urandom_range(0, 255));
        b_i     = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        check({tag, "_valid"}, {7'b0, valid_o}, 8'h00);
        check({tag, "_p"}, p_o, 8'h00);
        @(negedge clk);
    endtask

    task automatic clear_model();
        exp_q.delete();
        vpipe = 4'b0000;
        exp_p = 8'h00;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rv;

        // Reset held for 5 cycles with toggling inputs
        for (int i = 0; i < 5; i++) reset_step("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h5A, 8'hA5, 8'h00, "post_reset_idle");

        // Single operation: 0x45*0x45 = 0x1299
        step(1'b1, 8'h45, 8'h45, 8'h99, "single_in");
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 8'h00, 8'h00, "single_wait");

        // Back-to-back: 0x1C39, 0x2189, 0x27D9
        step(1'b1, 8'h55, 8'h55, 8'h39, "b2b_0");
        step(1'b1, 8'h55, 8'h65, 8'h89, "b2b_1");
        step(1'b1, 8'h65, 8'h65, 8'hD9, "b2b_2");
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 8'h00, 8'h00, "b2b_drain");

        // Idle inputs must not disturb the held result
        for (int i = 0; i < 100; i++) step(1'b0, 8'h12, 8'h34, 8'h00, "idle_hold");
        for (int i = 0; i < 4; i++) step(1'b0, 8'hxx, 8'hxx, 8'h00, "idle_x");

        // Corners, with a gap pattern in the middle
        step(1'b1, 8'hFF, 8'hFF, 8'h01, "corner_ff_ff");
        step(1'b0, 8'h00, 8'h00, 8'h00, "corner_gap");
        step(1'b1, 8'h00, 8'hAB, 8'h00, "corner_00_ab");
        step(1'b1, 8'h01, 8'hC3, 8'hC3, "corner_01_c3");
        step(1'b0, 8'h77, 8'h77, 8'h00, "corner_gap");
        step(1'b0, 8'h77, 8'h77, 8'h00, "corner_gap");
        step(1'b1, 8'h10, 8'h10, 8'h00, "corner_10_10");
        step(1'b1, 8'h0F, 8'h11, 8'hFF, "corner_0f_11");
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 8'h00, 8'h00, "corner_drain");

        // Random stream with random gaps
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            step(rv, ra, rb, 8'(ra * rb), "random");
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 8'h00, 8'h00, "random_drain");

        // Reset mid-flight: first result out, two still in the pipe
        step(1'b1, 8'h03, 8'h05, 8'h0F, "flight_0");
        step(1'b1, 8'h07, 8'h09, 8'h3F, "flight_1");
        step(1'b1, 8'h0B, 8'h0D, 8'h8F, "flight_2");
        step(1'b0, 8'h00, 8'h00, 8'h00, "flight_3");
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", {7'b0, valid_o}, 8'h00);
        check("midreset_p", p_o, 8'h00);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 8'h00, 8'h00, "after_midreset");

        // First op after release still takes 4 edges
        step(1'b1, 8'h0C, 8'h0C, 8'h90, "after_release_op");
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 8'h00, 8'h00, "after_release_wait");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
